// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg
// Shared definitions for the PS/2 game-key decoder:
//   - decoder FSM state encoding
//   - prefix bytes (E0 extended, F0 break) and the controller status bytes
//     that are dropped when they arrive outside a sequence
//   - the eight game-key scancodes and their key indices
//   - event word layout {make, idx}
//   - scancode lookup helpers for plain and E0-prefixed codes
package ps2_key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_F0 = 8'hF0;

    // Keyboard status/response bytes, never part of a key sequence.
    localparam logic [7:0] IGN_BAT_OK = 8'hAA;
    localparam logic [7:0] IGN_ACK    = 8'hFA;
    localparam logic [7:0] IGN_RESEND = 8'hFE;
    localparam logic [7:0] IGN_ECHO   = 8'hEE;
    localparam logic [7:0] IGN_ERR_LO = 8'h00;
    localparam logic [7:0] IGN_ERR_HI = 8'hFF;

    localparam int NUM_KEYS = 8;
    localparam int IDX_W    = 3;
    localparam int EVT_W    = IDX_W + 1;

    // Plain scancodes.
    localparam logic [7:0] SC_Z     = 8'h1A;
    localparam logic [7:0] SC_X     = 8'h22;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ESC   = 8'h76;
    // E0-prefixed scancodes.
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [IDX_W-1:0] IDX_Z     = 3'd0;
    localparam logic [IDX_W-1:0] IDX_X     = 3'd1;
    localparam logic [IDX_W-1:0] IDX_SPACE = 3'd2;
    localparam logic [IDX_W-1:0] IDX_ESC   = 3'd3;
    localparam logic [IDX_W-1:0] IDX_UP    = 3'd4;
    localparam logic [IDX_W-1:0] IDX_DOWN  = 3'd5;
    localparam logic [IDX_W-1:0] IDX_LEFT  = 3'd6;
    localparam logic [IDX_W-1:0] IDX_RIGHT = 3'd7;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } key_lookup_t;

    function automatic logic is_ignored(input logic [7:0] code);
        return (code == IGN_BAT_OK) || (code == IGN_ACK)    ||
               (code == IGN_RESEND) || (code == IGN_ECHO)   ||
               (code == IGN_ERR_LO) || (code == IGN_ERR_HI);
    endfunction

    function automatic key_lookup_t lookup_base(input logic [7:0] code);
        key_lookup_t r;
        r.hit = 1'b1;
        r.idx = IDX_Z;
        case (code)
            SC_Z:     r.idx = IDX_Z;
            SC_X:     r.idx = IDX_X;
            SC_SPACE: r.idx = IDX_SPACE;
            SC_ESC:   r.idx = IDX_ESC;
            default:  r.hit = 1'b0;
        endcase
        return r;
    endfunction

    function automatic key_lookup_t lookup_ext(input logic [7:0] code);
        key_lookup_t r;
        r.hit = 1'b1;
        r.idx = IDX_UP;
        case (code)
            SC_UP:    r.idx = IDX_UP;
            SC_DOWN:  r.idx = IDX_DOWN;
            SC_LEFT:  r.idx = IDX_LEFT;
            SC_RIGHT: r.idx = IDX_RIGHT;
            default:  r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo
// First-word-fall-through event queue with sticky overflow flag.
// A push and a pop in the same cycle are both honoured, even when full.
// A push into a full queue without a pop is dropped and sets overflow;
// a drop in the same cycle as ovf_clr leaves overflow set.
// Ports:
//   clk, reset       clock, synchronous active-low reset (empties the queue)
//   push, push_data  write request and word
//   pop              remove head (ignored when empty)
//   pop_data         head word, 0 when empty
//   count            number of stored words (0..FIFO_DEPTH)
//   full, empty      status
//   ovf_clr          clear overflow
//   overflow         sticky drop indicator
// FIFO_DEPTH must be a power of two, at least 2.
module ps2_event_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             pop_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty,
    input  logic                          ovf_clr,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt_q;
    logic              pop_en;
    logic              push_en;
    logic              drop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_CNT);
    assign count   = cnt_q;
    assign pop_en  = pop && !empty;
    // A simultaneous pop frees the slot the push needs.
    assign push_en = push && (!full || pop_en);
    assign drop    = push && full && !pop_en;

    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_en, pop_en})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Turns PS/2 make/break scancode bytes into held state, one-cycle
// press/release pulses and a queue of {make, idx} events for eight game keys.
// Configuration macro: PS2_KEY_EXT_EN enables the E0-prefixed keys
// (indices 4..7). Without it E0 sequences are still consumed by the FSM but
// have no key effect and bits 7:4 of the key outputs stay 0.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   ps2_byte/_en        received byte and its one-cycle strobe
//   key_held            held state per key index
//   key_press/_release  one-cycle edge pulses per key index
//   evt_valid/_data     head of event queue, {make, idx[2:0]}
//   evt_ready           pop head event
//   overflow, ovf_clr   sticky event-drop flag and its clear
// Latency: byte strobe sampled at edge N updates key state and queue at N+1.
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          ps2_byte,
    input  logic                ps2_byte_en,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                evt_valid,
    output logic [EVT_W-1:0]    evt_data,
    input  logic                evt_ready,
    output logic                overflow,
    input  logic                ovf_clr
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    function automatic key_lookup_t lookup(input logic ext, input logic [7:0] code);
`ifdef PS2_KEY_EXT_EN
        return ext ? lookup_ext(code) : lookup_base(code);
`else
        return ext ? key_lookup_t'(0) : lookup_base(code);
`endif
    endfunction

    ps2_state_t          state;
    ps2_state_t          state_next;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                tmo_hit;
    logic                dec_vld;
    logic                dec_make;
    logic                dec_ext;
    key_lookup_t         lk;

    logic                vld_p0;
    logic                make_p0;
    logic [IDX_W-1:0]    idx_p0;

    logic [NUM_KEYS-1:0] held_p1;
    logic [NUM_KEYS-1:0] press_p1;
    logic [NUM_KEYS-1:0] release_p1;
    logic                evt_hit;

    logic                fifo_empty;
    logic                fifo_full;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                unused_fifo_status;

    // Stuck-prefix guard: counts only while a sequence is open.
    assign tmo_hit = (state != ST_IDLE) && (tmo_cnt == TMO_LIMIT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (ps2_byte_en || state == ST_IDLE) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_LIMIT) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        dec_vld    = 1'b0;
        dec_make   = 1'b0;
        dec_ext    = 1'b0;
        if (ps2_byte_en) begin
            case (state)
                ST_IDLE: begin
                    if (ps2_byte == CODE_F0)      state_next = ST_BRK;
                    else if (ps2_byte == CODE_E0) state_next = ST_EXT;
                    else if (!is_ignored(ps2_byte)) begin
                        dec_vld  = 1'b1;
                        dec_make = 1'b1;
                    end
                end
                ST_BRK: begin
                    if (ps2_byte == CODE_E0)      state_next = ST_EXT;
                    else if (ps2_byte == CODE_F0) state_next = ST_BRK;
                    else begin
                        dec_vld    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (ps2_byte == CODE_F0)      state_next = ST_EXT_BRK;
                    else if (ps2_byte == CODE_E0) state_next = ST_EXT;
                    else begin
                        dec_vld    = 1'b1;
                        dec_make   = 1'b1;
                        dec_ext    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (ps2_byte == CODE_E0)      state_next = ST_EXT;
                    else if (ps2_byte == CODE_F0) state_next = ST_EXT_BRK;
                    else begin
                        dec_vld    = 1'b1;
                        dec_ext    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_next = ST_IDLE;
        end
        lk = lookup(dec_ext, ps2_byte);
    end

    // ---- stage p0: registered decode result ----
    always_ff @(posedge clk) begin
        if (!reset) vld_p0 <= 1'b0;
        else        vld_p0 <= dec_vld && lk.hit;
    end

    always_ff @(posedge clk) begin
        make_p0 <= dec_make;
        idx_p0  <= lk.idx;
    end

    // ---- stage p1: key state, pulses, event push ----
    // A make only counts when the key is up, a break only when it is down,
    // so typematic repeats and stray breaks fall out of one comparison.
    assign evt_hit = vld_p0 && (make_p0 != held_p1[idx_p0]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            held_p1    <= '0;
            press_p1   <= '0;
            release_p1 <= '0;
        end else begin
            press_p1   <= '0;
            release_p1 <= '0;
            if (evt_hit) begin
                held_p1[idx_p0] <= make_p0;
                if (make_p0) press_p1[idx_p0]   <= 1'b1;
                else         release_p1[idx_p0] <= 1'b1;
            end
        end
    end

    assign key_held    = held_p1;
    assign key_press   = press_p1;
    assign key_release = release_p1;

    ps2_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (evt_hit),
        .push_data ({make_p0, idx_p0}),
        .pop       (evt_ready),
        .pop_data  (evt_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow)
    );

    assign evt_valid = !fifo_empty;

    // Queue level/full are not needed by the decoder itself.
    assign unused_fifo_status = ^{fifo_count, fifo_full};

endmodule

// File: tb/tb_ps2_key_decoder.sv
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    localparam int DEPTH = 8;
    localparam int TMO   = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] ps2_byte = 8'h00;
    logic       ps2_byte_en = 1'b0;
    logic [7:0] key_held;
    logic [7:0] key_press;
    logic [7:0] key_release;
    logic       evt_valid;
    logic [3:0] evt_data;
    logic       evt_ready = 1'b0;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_byte    (ps2_byte),
        .ps2_byte_en (ps2_byte_en),
        .key_held    (key_held),
        .key_press   (key_press),
        .key_release (key_release),
        .evt_valid   (evt_valid),
        .evt_data    (evt_data),
        .evt_ready   (evt_ready),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    int checks = 0;
    int errors = 0;
    int press_cnt [8];
    int rel_cnt   [8];
    logic [3:0] got   [$];
    logic [3:0] exp_q [$];

    always @(negedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (key_press[k])   press_cnt[k]++;
            if (key_release[k]) rel_cnt[k]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr_counts();
        @(negedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            press_cnt[k] = 0;
            rel_cnt[k]   = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ps2_byte    = b;
        ps2_byte_en = 1'b1;
        @(negedge clk);
        ps2_byte_en = 1'b0;
        ps2_byte    = 8'h00;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic drain();
        got.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (evt_valid) begin
                got.push_back(evt_data);
                evt_ready = 1'b1;
            end else begin
                evt_ready = 1'b0;
            end
        end
        evt_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (key_held !== 8'h00) begin errors++; $display("FAIL rst_held got=%h want=00", key_held); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_evt_valid got=%b want=0", evt_valid); end
        send_byte(8'h1A);
        settle();
        do_reset();
        @(negedge clk);
        checks++; if (key_held !== 8'h00) begin errors++; $display("FAIL rst2_held got=%h want=00", key_held); end
        checks++; if (key_press !== 8'h00) begin errors++; $display("FAIL rst2_press got=%h want=00", key_press); end
        checks++; if (key_release !== 8'h00) begin errors++; $display("FAIL rst2_release got=%h want=00", key_release); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst2_evt_valid got=%b want=0", evt_valid); end
        checks++; if (evt_data !== 4'h0) begin errors++; $display("FAIL rst2_evt_data got=%h want=0", evt_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst2_overflow got=%b want=0", overflow); end
    endtask

    task automatic test_make_break();
        clr_counts();
        send_byte(8'h1A);
        @(negedge clk);
        checks++; if (key_press !== 8'h01) begin errors++; $display("FAIL mk_press_latency got=%h want=01", key_press); end
        checks++; if (key_held !== 8'h01) begin errors++; $display("FAIL mk_held got=%h want=01", key_held); end
        @(negedge clk);
        checks++; if (key_press !== 8'h00) begin errors++; $display("FAIL mk_press_width got=%h want=00", key_press); end
        send_byte(8'h1A);
        settle();
        checks++; if (key_held !== 8'h01) begin errors++; $display("FAIL mk_repeat_held got=%h want=01", key_held); end
        send_byte(8'hF0);
        send_byte(8'h1A);
        settle();
        checks++; if (press_cnt[0] != 1) begin errors++; $display("FAIL mk_press_count got=%0d want=1", press_cnt[0]); end
        checks++; if (rel_cnt[0] != 1) begin errors++; $display("FAIL mk_release_count got=%0d want=1", rel_cnt[0]); end
        checks++; if (key_held !== 8'h00) begin errors++; $display("FAIL mk_break_held got=%h want=00", key_held); end
        drain();
        exp_q = '{4'h8, 4'h0};
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL mk_evt_count got=%0d want=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mk_evt[%0d] got=%h want=%h", i, (i < got.size()) ? got[i] : 4'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_ext();
        clr_counts();
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h76);
        send_byte(8'hAA); send_byte(8'hFA);
        send_byte(8'h29);
        settle();
        checks++; if (key_held !== 8'h04) begin errors++; $display("FAIL ext_space_held got=%h want=04", key_held); end
        send_byte(8'hF0); send_byte(8'h29);
        settle();
`ifdef PS2_KEY_EXT_EN
        checks++; if (press_cnt[4] != 1) begin errors++; $display("FAIL ext_up_press got=%0d want=1", press_cnt[4]); end
        checks++; if (rel_cnt[4] != 1) begin errors++; $display("FAIL ext_up_release got=%0d want=1", rel_cnt[4]); end
        exp_q = '{4'hC, 4'h4, 4'hA, 4'h2};
`else
        checks++; if (press_cnt[4] != 0) begin errors++; $display("FAIL ext_up_press got=%0d want=0", press_cnt[4]); end
        checks++; if (rel_cnt[4] != 0) begin errors++; $display("FAIL ext_up_release got=%0d want=0", rel_cnt[4]); end
        exp_q = '{4'hA, 4'h2};
`endif
        checks++; if (press_cnt[3] != 0) begin errors++; $display("FAIL ext_e0_76_not_esc got=%0d want=0", press_cnt[3]); end
        checks++; if (press_cnt[2] != 1) begin errors++; $display("FAIL ext_space_press got=%0d want=1", press_cnt[2]); end
        drain();
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL ext_evt_count got=%0d want=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ext_evt[%0d] got=%h want=%h", i, (i < got.size()) ? got[i] : 4'hx, exp_q[i]);
            end
        end
    endtask

    task automatic fill_eight();
        send_byte(8'h1A); send_byte(8'h22); send_byte(8'h29); send_byte(8'h76);
        send_byte(8'hF0); send_byte(8'h1A);
        send_byte(8'hF0); send_byte(8'h22);
        send_byte(8'hF0); send_byte(8'h29);
        send_byte(8'hF0); send_byte(8'h76);
    endtask

    task automatic test_overflow();
        evt_ready = 1'b0;
        fill_eight();
        send_byte(8'h1A);
        settle();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", overflow); end
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b want=0", overflow); end
        send_byte(8'hF0);
        send_byte(8'h1A);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b want=1", overflow); end
        checks++; if (key_held !== 8'h00) begin errors++; $display("FAIL ovf_held got=%h want=00", key_held); end
        drain();
        exp_q = '{4'h8, 4'h9, 4'hA, 4'hB, 4'h0, 4'h1, 4'h2, 4'h3};
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL ovf_evt_count got=%0d want=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_evt[%0d] got=%h want=%h", i, (i < got.size()) ? got[i] : 4'hx, exp_q[i]);
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr2 got=%b want=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        evt_ready = 1'b0;
        fill_eight();
        send_byte(8'h1A);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        settle();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got=%b want=0", overflow); end
        drain();
        exp_q = '{4'h9, 4'hA, 4'hB, 4'h0, 4'h1, 4'h2, 4'h3, 4'h8};
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL fpp_evt_count got=%0d want=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL fpp_evt[%0d] got=%h want=%h", i, (i < got.size()) ? got[i] : 4'hx, exp_q[i]);
            end
        end
        send_byte(8'hF0); send_byte(8'h1A);
        drain();
    endtask

    task automatic test_timeout();
        clr_counts();
        send_byte(8'hF0);
        repeat (TMO + 2) @(negedge clk);
        send_byte(8'h22);
        settle();
        checks++; if (press_cnt[1] != 1) begin errors++; $display("FAIL tmo_press got=%0d want=1", press_cnt[1]); end
        checks++; if (key_held !== 8'h02) begin errors++; $display("FAIL tmo_held got=%h want=02", key_held); end
        send_byte(8'hF0);
        repeat (5) @(negedge clk);
        send_byte(8'h22);
        settle();
        checks++; if (rel_cnt[1] != 1) begin errors++; $display("FAIL tmo_early_release got=%0d want=1", rel_cnt[1]); end
        checks++; if (key_held !== 8'h00) begin errors++; $display("FAIL tmo_early_held got=%h want=00", key_held); end
        drain();
        exp_q = '{4'h9, 4'h1};
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL tmo_evt_count got=%0d want=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL tmo_evt[%0d] got=%h want=%h", i, (i < got.size()) ? got[i] : 4'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clr_counts();
        send_byte(8'h29);
        send_byte(8'hE0); send_byte(8'hF0);
        do_reset();
        send_byte(8'h6B);
        settle();
        checks++; if (press_cnt[6] != 0) begin errors++; $display("FAIL rmid_left_press got=%0d want=0", press_cnt[6]); end
        checks++; if (key_held !== 8'h00) begin errors++; $display("FAIL rmid_held got=%h want=00", key_held); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rmid_fifo_empty got=%b want=0", evt_valid); end
        checks++; if (evt_data !== 4'h0) begin errors++; $display("FAIL rmid_evt_data got=%h want=0", evt_data); end
        send_byte(8'hE0);
        do_reset();
        send_byte(8'h6B);
        settle();
        checks++; if (press_cnt[6] != 0) begin errors++; $display("FAIL rmid_e0_left_press got=%0d want=0", press_cnt[6]); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rmid_e0_fifo_empty got=%b want=0", evt_valid); end
    endtask

    task automatic test_back_to_back();
        clr_counts();
        @(negedge clk);
        ps2_byte_en = 1'b1;
        ps2_byte = 8'h22; @(negedge clk);
        ps2_byte = 8'hF0; @(negedge clk);
        ps2_byte = 8'h22; @(negedge clk);
        ps2_byte = 8'h1A; @(negedge clk);
        ps2_byte_en = 1'b0;
        ps2_byte = 8'h00;
        settle();
        checks++; if (press_cnt[1] != 1) begin errors++; $display("FAIL b2b_x_press got=%0d want=1", press_cnt[1]); end
        checks++; if (rel_cnt[1] != 1) begin errors++; $display("FAIL b2b_x_release got=%0d want=1", rel_cnt[1]); end
        checks++; if (press_cnt[0] != 1) begin errors++; $display("FAIL b2b_z_press got=%0d want=1", press_cnt[0]); end
        checks++; if (key_held !== 8'h01) begin errors++; $display("FAIL b2b_held got=%h want=01", key_held); end
        drain();
        exp_q = '{4'h9, 4'h1, 4'h8};
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL b2b_evt_count got=%0d want=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_evt[%0d] got=%h want=%h", i, (i < got.size()) ? got[i] : 4'hx, exp_q[i]);
            end
        end
        send_byte(8'hF0); send_byte(8'h1A);
        drain();
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_ext();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
